// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared command codes, host FSM states and widths for the
//               LCD command host.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_WRITE       = 3'd0,
        CMD_SHIFT_UP    = 3'd1,
        CMD_SHIFT_DOWN  = 3'd2,
        CMD_SHIFT_LEFT  = 3'd3,
        CMD_SHIFT_RIGHT = 3'd4,
        CMD_AVERAGE     = 3'd5,
        CMD_MIRROR_X    = 3'd6,
        CMD_MIRROR_Y    = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_WAIT_RDY  = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_GAP       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_FINISHED  = 3'd4,
        ST_ERROR     = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cmd_fifo
// Description : Synchronous circular-buffer FIFO; pushes while full and pops
//               while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_fifo #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/lcd_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : lcd_cmd_host
// Description : Buffers LCD commands and issues them to the controller under
//               the busy/done handshake, with counters and a watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_cmd_host
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CW          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [CMD_W-1:0]         push_cmd,
    output logic                     push_ready,
    output logic [CMD_W-1:0]         cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CW-1:0]            issued_cnt,
    output logic                     all_done,
    output logic                     timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [CW-1:0]     issued_q, issued_d;
    logic              all_done_q, all_done_d;
    logic              timeout_q, timeout_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              waiting;
    logic              fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0]  fifo_head;

    lcd_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        issued_d    = issued_q;
        all_done_d  = all_done_q;
        timeout_d   = timeout_q;
        wd_d        = '0;
        waiting     = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_WAIT_RDY: begin
                cmd_valid_d = 1'b0;
                if (!busy && !fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cmd_d       = fifo_head;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end else if (busy) begin
                    waiting = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!busy) begin
                    if (issued_q != '1) begin
                        issued_d = issued_q + CW'(1);
                    end
                    cmd_valid_d = 1'b0;
                    state_d     = (cmd_q == CMD_WRITE) ? ST_WAIT_DONE : ST_GAP;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_GAP: begin
                cmd_valid_d = 1'b0;
                state_d     = ST_WAIT_RDY;
            end
            ST_WAIT_DONE: begin
                cmd_valid_d = 1'b0;
                if (done) begin
                    all_done_d = 1'b1;
                    state_d    = ST_FINISHED;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_FINISHED: begin
                cmd_valid_d = 1'b0;
            end
            ST_ERROR: begin
                cmd_valid_d = 1'b0;
                timeout_d   = 1'b1;
            end
            default: begin
                cmd_valid_d = 1'b0;
                state_d     = ST_WAIT_RDY;
            end
        endcase

        // waiting is only raised when no done/transfer happened, so those events beat expiry
        if (waiting) begin
            if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                state_d     = ST_ERROR;
                timeout_d   = 1'b1;
                cmd_valid_d = 1'b0;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT_RDY;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            issued_q    <= '0;
            all_done_q  <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            issued_q    <= issued_d;
            all_done_q  <= all_done_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
        end
    end

    assign push_ready  = !fifo_full;
    assign cmd         = cmd_q;
    assign cmd_valid   = cmd_valid_q;
    assign issued_cnt  = issued_q;
    assign all_done    = all_done_q;
    assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_cmd_host
// Description : Self-checking bench for lcd_cmd_host: vector table, startup,
//               random command streams against a queue model, fill, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_cmd_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, push_valid, busy, done;
    logic [2:0]  push_cmd, cmd;
    logic        push_ready, cmd_valid, all_done, timeout_err;
    logic [6:0]  fifo_cnt;
    logic [15:0] issued_cnt;

    logic        t_reset, t_push_valid, t_busy, t_done;
    logic [2:0]  t_push_cmd, t_cmd;
    logic        t_push_ready, t_cmd_valid, t_all_done, t_timeout_err;
    logic [2:0]  t_fifo_cnt;
    logic [7:0]  t_issued_cnt;

    lcd_cmd_host #(.DEPTH(64), .TIMEOUT_CYC(4096), .CW(16)) dut (
        .clk(clk), .reset(reset), .push_valid(push_valid), .push_cmd(push_cmd),
        .push_ready(push_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .done(done), .fifo_cnt(fifo_cnt), .issued_cnt(issued_cnt),
        .all_done(all_done), .timeout_err(timeout_err)
    );

    lcd_cmd_host #(.DEPTH(4), .TIMEOUT_CYC(16), .CW(8)) dut_t (
        .clk(clk), .reset(t_reset), .push_valid(t_push_valid), .push_cmd(t_push_cmd),
        .push_ready(t_push_ready), .cmd(t_cmd), .cmd_valid(t_cmd_valid), .busy(t_busy),
        .done(t_done), .fifo_cnt(t_fifo_cnt), .issued_cnt(t_issued_cnt),
        .all_done(t_all_done), .timeout_err(t_timeout_err)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    int         n_xfer   = 0;
    int         busy_left = 0;
    int         done_left = 0;
    bit         auto_ctrl = 1'b0;
    bit         low_seen  = 1'b1;
    logic [2:0] q[$];

    typedef struct {
        bit         rst;
        bit         pv;
        logic [2:0] pc;
        bit         bz;
        bit         dn;
        bit         e_cv;
        logic [2:0] e_cmd;
        int         e_cnt;
        int         e_iss;
        bit         e_pr;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: the model learns which pushes/transfers happened at this edge,
    // checks occupancy invariants, then the optional controller model reacts.
    task automatic cyc();
        bit         pre_xfer, pre_push, pre_rst;
        logic [2:0] pre_cmd, pre_pcmd, exp_cmd;
        pre_rst  = reset;
        pre_xfer = cmd_valid && !busy && !reset;
        pre_push = push_valid && push_ready && !reset;
        pre_cmd  = cmd;
        pre_pcmd = push_cmd;
        @(posedge clk);
        #1;
        if (pre_rst) begin
            q.delete();
            n_xfer   = 0;
            low_seen = 1'b1;
            done_left = 0;
            busy_left = auto_ctrl ? 5 : 0;
        end else begin
            if (pre_push) q.push_back(pre_pcmd);
            if (pre_xfer) begin
                n_xfer++;
                if (q.size() == 0) begin
                    check("xfer_unexpected", 1, 0);
                end else begin
                    exp_cmd = q.pop_front();
                    check("xfer_order", pre_cmd, exp_cmd);
                end
                check("xfer_gap", low_seen, 1);
                low_seen = 1'b0;
                if (auto_ctrl) begin
                    busy_left = 3;
                    if (pre_cmd == 3'd0) done_left = 64;
                end
            end
        end
        if (!cmd_valid) low_seen = 1'b1;
        check("occupancy", fifo_cnt + cmd_valid, q.size());
        check("push_ready", push_ready, ((q.size() - cmd_valid) != 64) ? 1 : 0);
        check("issued_cnt", issued_cnt, n_xfer);
        if (auto_ctrl) begin
            busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            done = 1'b0;
            if (done_left > 0) begin
                done_left--;
                if (done_left == 0) done = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [2:0] list[$];
        int  idx;
        bit  will, cv_seen;

        reset = 1'b1; push_valid = 1'b0; push_cmd = 3'd0; busy = 1'b0; done = 1'b0;
        t_reset = 1'b1; t_push_valid = 1'b0; t_push_cmd = 3'd0; t_busy = 1'b0; t_done = 1'b0;

        //          rst pv pc   bz dn   cv cmd  cnt iss pr
        tbl[0]  = '{1, 0, 3'd0, 0, 0,   0, 3'd0, 0, 0, 1};
        tbl[1]  = '{0, 1, 3'd4, 0, 0,   0, 3'd0, 1, 0, 1};
        tbl[2]  = '{0, 0, 3'd0, 0, 0,   1, 3'd4, 0, 0, 1};
        tbl[3]  = '{0, 1, 3'd2, 1, 0,   1, 3'd4, 1, 0, 1};
        tbl[4]  = '{0, 1, 3'd6, 1, 0,   1, 3'd4, 2, 0, 1};
        tbl[5]  = '{1, 1, 3'd3, 1, 0,   0, 3'd0, 0, 0, 1};
        tbl[6]  = '{0, 1, 3'd2, 0, 0,   0, 3'd0, 1, 0, 1};
        tbl[7]  = '{0, 0, 3'd0, 0, 0,   1, 3'd2, 0, 0, 1};
        tbl[8]  = '{0, 0, 3'd0, 0, 0,   0, 3'd2, 0, 1, 1};
        tbl[9]  = '{0, 0, 3'd0, 1, 1,   0, 3'd2, 0, 1, 1};
        tbl[10] = '{0, 1, 3'd7, 0, 0,   0, 3'd2, 1, 1, 1};
        tbl[11] = '{0, 0, 3'd0, 0, 0,   1, 3'd7, 0, 1, 1};
        tbl[12] = '{0, 0, 3'd0, 0, 0,   0, 3'd7, 0, 2, 1};
        tbl[13] = '{0, 1, 3'd5, 1, 0,   0, 3'd7, 1, 2, 1};
        tbl[14] = '{0, 1, 3'd1, 0, 0,   1, 3'd5, 1, 2, 1};
        tbl[15] = '{0, 0, 3'd0, 0, 0,   0, 3'd5, 1, 3, 1};
        tbl[16] = '{0, 0, 3'd0, 0, 1,   0, 3'd5, 1, 3, 1};
        tbl[17] = '{0, 0, 3'd0, 0, 0,   1, 3'd1, 0, 3, 1};
        tbl[18] = '{1, 0, 3'd0, 0, 0,   0, 3'd0, 0, 0, 1};

        // Vector table: latency, busy during ISSUE, reset mid-transfer, push+pop at count 1
        for (int i = 0; i < 19; i++) begin
            reset = tbl[i].rst; push_valid = tbl[i].pv; push_cmd = tbl[i].pc;
            busy = tbl[i].bz; done = tbl[i].dn;
            cyc();
            check($sformatf("vec%0d_cmd_valid", i), cmd_valid, tbl[i].e_cv);
            check($sformatf("vec%0d_cmd", i), cmd, tbl[i].e_cmd);
            check($sformatf("vec%0d_fifo_cnt", i), fifo_cnt, tbl[i].e_cnt);
            check($sformatf("vec%0d_issued", i), issued_cnt, tbl[i].e_iss);
            check($sformatf("vec%0d_push_ready", i), push_ready, tbl[i].e_pr);
            check($sformatf("vec%0d_all_done", i), all_done, 0);
        end
        reset = 1'b0; push_valid = 1'b0; busy = 1'b0; done = 1'b0;

        // Startup: busy held high with {1,5,0} queued; nothing issues until busy drops
        reset = 1'b1; cyc(); reset = 1'b0;
        busy = 1'b1; cv_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push_valid = (i < 3);
            push_cmd   = (i == 0) ? 3'd1 : ((i == 1) ? 3'd5 : 3'd0);
            cyc();
            if (cmd_valid) cv_seen = 1'b1;
        end
        push_valid = 1'b0;
        check("startup_no_issue", cv_seen, 0);
        check("startup_fifo_cnt", fifo_cnt, 3);
        auto_ctrl = 1'b1; busy_left = 0; done_left = 0; busy = 1'b0;
        for (int c = 0; c < 400 && !all_done; c++) cyc();
        check("startup_xfers", n_xfer, 3);
        check("startup_issued", issued_cnt, 3);
        check("startup_all_done", all_done, 1);
        check("startup_timeout", timeout_err, 0);

        // 44 random non-Write commands then a Write, pushed with random gaps
        reset = 1'b1; cyc(); reset = 1'b0;
        list.delete();
        for (int i = 0; i < 44; i++) list.push_back(3'($urandom_range(1, 7)));
        list.push_back(3'd0);
        idx = 0;
        for (int c = 0; c < 6000 && !all_done; c++) begin
            push_valid = (idx < 45) && ($urandom_range(0, 3) != 0);
            if (idx < 45) push_cmd = list[idx];
            will = push_valid && push_ready;
            cyc();
            if (will) idx++;
        end
        push_valid = 1'b0;
        check("seq45_pushed", idx, 45);
        check("seq45_xfers", n_xfer, 45);
        check("seq45_queue_left", q.size(), 0);
        check("seq45_all_done", all_done, 1);
        check("seq45_timeout", timeout_err, 0);

        // Fill with busy high: 70 pushes, only 64 accepted
        auto_ctrl = 1'b0; busy = 1'b1; done = 1'b0;
        reset = 1'b1; cyc(); reset = 1'b0;
        cv_seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            push_valid = 1'b1;
            push_cmd   = 3'($urandom_range(1, 7));
            cyc();
            if (cmd_valid) cv_seen = 1'b1;
            if (i == 62) check("fill_ready_at_63", push_ready, 1);
            if (i == 63) check("fill_ready_at_64", push_ready, 0);
        end
        push_valid = 1'b0;
        check("fill_fifo_cnt", fifo_cnt, 64);
        check("fill_model_cnt", q.size(), 64);
        check("fill_push_ready", push_ready, 0);
        check("fill_no_issue", cv_seen, 0);

        // Drain while pushing 130 more so both pointers wrap several times
        auto_ctrl = 1'b1; busy_left = 0; done_left = 0; busy = 1'b0;
        idx = 0;
        for (int c = 0; c < 5000 && (idx < 130 || q.size() != 0); c++) begin
            push_valid = (idx < 130) && ($urandom_range(0, 1) != 0);
            push_cmd   = 3'($urandom_range(1, 7));
            will = push_valid && push_ready;
            cyc();
            if (will) idx++;
        end
        push_valid = 1'b0;
        check("wrap_xfers", n_xfer, 194);
        check("wrap_issued", issued_cnt, 194);
        check("wrap_fifo_cnt", fifo_cnt, 0);
        check("wrap_timeout", timeout_err, 0);

        // Watchdog on the short-timeout instance: Write issued, done never arrives
        t_reset = 1'b1; cyc(); t_reset = 1'b0;
        t_busy = 1'b0; t_push_valid = 1'b1; t_push_cmd = 3'd0;
        cyc();
        t_push_valid = 1'b0;
        for (int c = 0; c < 10 && t_issued_cnt == 8'd0; c++) cyc();
        check("to_write_issued", t_issued_cnt, 1);
        check("to_cmd_valid_low", t_cmd_valid, 0);
        repeat (15) cyc();
        check("to_not_yet", t_timeout_err, 0);
        cyc();
        check("to_expired", t_timeout_err, 1);
        check("to_cmd_valid", t_cmd_valid, 0);
        t_done = 1'b1; cyc(); t_done = 1'b0; cyc();
        check("to_late_done", t_all_done, 0);
        check("to_sticky", t_timeout_err, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
